message_checker: RTL and testbench

MESSAGE_CHECKER -- requirements
Module: message_checker

---
 rtl/rc4_pkg.sv | 16 +
 rtl/msg_char_classifier.sv | 12 +
 rtl/message_checker.sv | 110 +++++++++++
 tb/tb_message_checker.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared state encoding and character-class constants for the decrypted-message checker.
package rc4_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_WAIT,
      ST_CHECK,
      ST_DONE
   } chk_state_e;

   localparam logic [7:0] CHAR_SPACE = 8'h20;
   localparam logic [7:0] CHAR_LOW_A = 8'h61;
   localparam logic [7:0] CHAR_LOW_Z = 8'h7A;

endpackage

// File: rtl/msg_char_classifier.sv
// Combinational byte classifier: a byte is legal when it is a space or a lowercase letter.
module msg_char_classifier
   import rc4_pkg::*;
(
   input  logic [7:0] char_i,
   output logic       legal_o
);

   assign legal_o = (char_i == CHAR_SPACE) ||
                    ((char_i >= CHAR_LOW_A) && (char_i <= CHAR_LOW_Z));

endmodule

// File: rtl/message_checker.sv
// Walks the decrypted-message RAM and reports whether every byte is legal text.
// Optional MSG_CHECK_BAD_INDEX_EN adds a bad_index output holding the first illegal position.
module message_checker
   import rc4_pkg::*;
#(
   parameter int MESSAGE_LENGTH = 32
)
(
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   output logic       finish,
   output logic [7:0] address,
   input  logic [7:0] q,
   output logic       key_valid,
   output logic       busy
`ifdef MSG_CHECK_BAD_INDEX_EN
   ,
   output logic [7:0] bad_index
`endif
);

   localparam logic [7:0] LAST_IDX = 8'(MESSAGE_LENGTH - 1);

   chk_state_e state_q, state_d;
   logic [7:0] index_q, index_d;
   logic       key_valid_q, key_valid_d;
   logic       legal;

   msg_char_classifier u_classifier (
      .char_i  (q),
      .legal_o (legal)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         index_q     <= 8'h00;
         key_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         index_q     <= index_d;
         key_valid_q <= key_valid_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      index_d     = index_q;
      key_valid_d = key_valid_q;
      finish      = 1'b0;
      address     = 8'h00;
      busy        = 1'b1;
      case (state_q)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) begin
               index_d = 8'h00;
               state_d = ST_ADDR;
            end
         end
         ST_ADDR: begin
            address = index_q;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            address = index_q;
            state_d = ST_CHECK;
         end
         ST_CHECK: begin
            address = index_q;
            if (!legal) begin
               key_valid_d = 1'b0;
               state_d     = ST_DONE;
            end else if (index_q == LAST_IDX) begin
               key_valid_d = 1'b1;
               state_d     = ST_DONE;
            end else begin
               index_d = index_q + 8'd1;
               state_d = ST_ADDR;
            end
         end
         ST_DONE: begin
            finish  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign key_valid = key_valid_q;

`ifdef MSG_CHECK_BAD_INDEX_EN
   logic [7:0] bad_index_q, bad_index_d;

   // Only an illegal-byte decision updates the position; all-legal runs leave it as is.
   always_comb begin
      bad_index_d = bad_index_q;
      if ((state_q == ST_CHECK) && !legal) bad_index_d = index_q;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) bad_index_q <= 8'h00;
      else       bad_index_q <= bad_index_d;
   end

   assign bad_index = bad_index_q;
`endif

endmodule

// File: tb/tb_message_checker.sv
// Scoreboard bench for message_checker: stimulus pushes expected run results, a monitor pops them on finish.
module tb_message_checker;

   typedef struct {
      int         lat;
      bit         kv;
      int         maxa;
      logic [7:0] bad;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0, start1 = 1'b0;
   logic [7:0] q, q1, address, address1;
   logic       finish, key_valid, busy, finish1, key_valid1, busy1;
`ifdef MSG_CHECK_BAD_INDEX_EN
   logic [7:0] bad_index, bad_index1;
`endif

   logic [7:0] mem  [256];
   logic [7:0] mem1 [256];
   exp_t       sb[$];
   exp_t       sb1[$];
   int         n_chk = 0, n_fail = 0, cyc = 0;
   int         t0 = 0, t01 = 0, maxa = 0, nfin = 0, nfin1 = 0;
   bit         last_kv = 1'b0;
   logic [7:0] exp_bad = 8'h00;

   message_checker #(.MESSAGE_LENGTH(32)) dut (
      .clock(clk), .reset(rst), .start(start), .finish(finish), .address(address),
      .q(q), .key_valid(key_valid), .busy(busy)
`ifdef MSG_CHECK_BAD_INDEX_EN
      , .bad_index(bad_index)
`endif
   );

   message_checker #(.MESSAGE_LENGTH(1)) dut1 (
      .clock(clk), .reset(rst), .start(start1), .finish(finish1), .address(address1),
      .q(q1), .key_valid(key_valid1), .busy(busy1)
`ifdef MSG_CHECK_BAD_INDEX_EN
      , .bad_index(bad_index1)
`endif
   );

   always #5 clk = ~clk;

   // RAM models with one cycle of read latency
   always @(posedge clk) begin
      q  <= mem[address];
      q1 <= mem1[address1];
   end

   task automatic chk(string name, longint act, longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (rst) begin
         last_kv = 1'b0;
         chk("rst_address", address, 0);
         chk("rst_finish", finish, 0);
         chk("rst_key_valid", key_valid, 0);
         chk("rst_busy", busy, 0);
         chk("rst_address1", address1, 0);
      end else begin
         if (!busy || finish) chk("address_zero_idle_done", address, 0);
         if (!busy) chk("key_valid_hold", key_valid, last_kv);
         if (busy && int'(address) > maxa) maxa = int'(address);
         if (finish) begin
            nfin++;
            if (sb.size() == 0) chk("unexpected_finish", 1, 0);
            else begin
               e = sb.pop_front();
               chk("latency", cyc - t0, e.lat);
               chk("key_valid", key_valid, e.kv);
               chk("max_address", maxa, e.maxa);
`ifdef MSG_CHECK_BAD_INDEX_EN
               chk("bad_index", bad_index, e.bad);
`endif
            end
            last_kv = key_valid;
         end
         if (!busy && start) begin
            t0   = cyc;
            maxa = 0;
         end
         if (finish1) begin
            nfin1++;
            if (sb1.size() == 0) chk("unexpected_finish1", 1, 0);
            else begin
               e = sb1.pop_front();
               chk("latency1", cyc - t01, e.lat);
               chk("key_valid1", key_valid1, e.kv);
               chk("address1_done", address1, 0);
`ifdef MSG_CHECK_BAD_INDEX_EN
               chk("bad_index1", bad_index1, e.bad);
`endif
            end
         end
         if (!busy1 && start1) t01 = cyc;
      end
   end

   task automatic wait_fin(bit which, int target, int budget);
      int k = 0;
      while (((which ? nfin1 : nfin) < target) && (k < budget)) begin
         @(negedge clk);
         #1;
         k++;
      end
      chk("finish_timeout", (which ? nfin1 : nfin) >= target, 1);
   endtask

   task automatic push_exp(int lat, bit kv, int maxa_e, bit bad_upd, int bad_i);
      exp_t e;
      if (bad_upd) exp_bad = bad_i[7:0];
      e.lat  = lat;
      e.kv   = kv;
      e.maxa = maxa_e;
      e.bad  = exp_bad;
      sb.push_back(e);
   endtask

   task automatic run(int lat, bit kv, int maxa_e, bit bad_upd, int bad_i);
      int tgt = nfin + 1;
      push_exp(lat, kv, maxa_e, bad_upd, bad_i);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_fin(1'b0, tgt, 200);
      repeat (2) @(posedge clk);
   endtask

   task automatic run1(bit kv);
      exp_t e;
      int   tgt = nfin1 + 1;
      e.lat = 4; e.kv = kv; e.maxa = 0; e.bad = 8'h00;
      sb1.push_back(e);
      @(posedge clk); #1 start1 = 1'b1;
      @(posedge clk); #1 start1 = 1'b0;
      wait_fin(1'b1, tgt, 20);
      repeat (2) @(posedge clk);
   endtask

   task automatic fill_legal();
      string s = "attack at dawn attack at dawn ok";
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      for (int i = 0; i < 32; i++) mem[i] = s[i];
   endtask

   initial begin
      logic [7:0] pass_b [3];
      logic [7:0] fail_b [3];
      int         tgt;
      pass_b = '{8'h20, 8'h61, 8'h7A};
      fail_b = '{8'h1F, 8'h60, 8'h7B};
      for (int i = 0; i < 256; i++) mem1[i] = 8'h00;
      fill_legal();

      #1;
      chk("reset_busy", busy, 0);
      chk("reset_address", address, 0);
      chk("reset_key_valid", key_valid, 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);

      run(97, 1'b1, 31, 1'b0, 0);

      mem[5] = 8'h41;
      run(19, 1'b0, 5, 1'b1, 5);
      fill_legal();

      for (int b = 0; b < 3; b++) begin
         mem[0] = pass_b[b];
         run(97, 1'b1, 31, 1'b0, 0);
         mem[0] = fail_b[b];
         run(4, 1'b0, 0, 1'b1, 0);
      end
      fill_legal();

      mem[31] = 8'h7B;
      run(97, 1'b0, 31, 1'b1, 31);
      fill_legal();

      // Abandoned run: reset lands in the middle, no finish may follow
      tgt = nfin;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (39) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrun_address", address, 0);
      chk("midrun_busy", busy, 0);
      chk("midrun_finish", finish, 0);
      chk("midrun_key_valid", key_valid, 0);
`ifdef MSG_CHECK_BAD_INDEX_EN
      chk("midrun_bad_index", bad_index, 0);
`endif
      exp_bad = 8'h00;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (5) @(posedge clk);
      chk("midrun_no_finish", nfin, tgt);
      run(97, 1'b1, 31, 1'b0, 0);

      // Start held high: three back-to-back runs failing at index 2
      mem[2] = 8'h60;
      tgt = nfin + 3;
      for (int r = 0; r < 3; r++) push_exp(10, 1'b0, 2, 1'b1, 2);
      @(posedge clk); #1 start = 1'b1;
      wait_fin(1'b0, tgt, 100);
      @(posedge clk); #1 start = 1'b0;
      repeat (6) @(posedge clk);
      chk("held_start_runs", nfin, tgt);
      chk("held_start_queue_empty", sb.size(), 0);
      fill_legal();

      mem1[0] = 8'h7A;
      run1(1'b1);
      mem1[0] = 8'h60;
      run1(1'b0);

      repeat (2) @(posedge clk);
      chk("scoreboard_empty", sb.size() + sb1.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got t=%0t required completion", $time);
      $fatal(1, "watchdog");
   end

endmodule
